// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a classic 5-stage core.
// Detects load-use hazards, holds the front end while a branch resolves,
// squashes IF/ID and ID/EX after a taken branch, and freezes everything
// while data memory is busy.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; without it the counter ports read as zero.
module hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic                  WB_sel,
  input  logic                  branch_ID,
  input  logic                  br_resolve_valid,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  stall_IFID,
  output logic                  stall_IDEX,
  output logic                  stall_EXMEM,
  output logic                  flush,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LD_STALL = 2'd1;
  localparam logic [1:0] BR_WAIT  = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  // The first stall/flush cycle is issued from RUN (or the resolving state),
  // so the counter only has to cover the remaining cycles.
  localparam logic [3:0] LD_RELOAD = 4'(LOAD_STALL_CYC - 1);
  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYC - 1);
  localparam logic       LD_MULTI  = (LOAD_STALL_CYC > 1);
  localparam logic       FL_MULTI  = (FLUSH_CYC > 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       stall_fe;   // stall IF/ID and ID/EX
  logic       stall_mem;  // additionally stall EX/MEM
  logic       flush_raw;

  // Load-use: EX holds a load whose destination an ID source reads; x0 never hazards.
  assign load_use = WB_sel && (rd_EX != '0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));

  // Next-state and raw outputs; priority mem_busy > taken flush > state actions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_fe  = 1'b0;
    stall_mem = 1'b0;
    flush_raw = 1'b0;
    if (mem_busy) begin
      // Freeze: state and cnt hold, a pending taken flush waits for memory.
      stall_fe  = 1'b1;
      stall_mem = 1'b1;
    end else if (br_resolve_valid && branch_taken) begin
      flush_raw = 1'b1;
      if (FL_MULTI) begin
        state_d = FLUSH;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            stall_fe = 1'b1;
            if (LD_MULTI) begin
              state_d = LD_STALL;
              cnt_d   = LD_RELOAD;
            end
          end else if (branch_ID) begin
            stall_fe = 1'b1;
            state_d  = BR_WAIT;
          end
        end
        LD_STALL: begin
          stall_fe = 1'b1;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
        BR_WAIT: begin
          // Not-taken resolution releases the front end in the same cycle.
          if (br_resolve_valid) state_d = RUN;
          else                  stall_fe = 1'b1;
        end
        FLUSH: begin
          flush_raw = 1'b1;
          cnt_d     = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by reset so they drop the instant reset asserts,
  // even if ID inputs would otherwise raise a combinational stall.
  assign stall_IFID  = reset_n & stall_fe;
  assign stall_IDEX  = reset_n & stall_fe;
  assign stall_EXMEM = reset_n & stall_mem;
  assign flush       = reset_n & flush_raw;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_IFID && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF))      flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant-vector table for single-cycle decisions,
// directed multi-cycle sequences, then random traffic against a model that
// tracks remaining stall/flush cycles.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int LSC = 3;
  localparam int FLC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rs1_ID, rs2_ID, rd_EX;
  logic          rs1_used_ID, rs2_used_ID, WB_sel, branch_ID;
  logic          br_resolve_valid, branch_taken, mem_busy;
  logic          stall_IFID, stall_IDEX, stall_EXMEM, flush;
  logic [31:0]   stall_cnt, flush_cnt;
  logic [3:0]    outs;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_STALL_CYC(LSC), .FLUSH_CYC(FLC)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .WB_sel(WB_sel), .branch_ID(branch_ID),
    .br_resolve_valid(br_resolve_valid), .branch_taken(branch_taken),
    .mem_busy(mem_busy),
    .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX), .stall_EXMEM(stall_EXMEM),
    .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign outs = {stall_IFID, stall_IDEX, stall_EXMEM, flush};

  typedef struct {
    logic          wb;
    logic [AW-1:0] rd, rs1, rs2;
    logic          u1, u2, br, rv, tk, mb;
    logic [3:0]    exp;  // {stall_IFID, stall_IDEX, stall_EXMEM, flush}
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic wb, input int rd, input int rs1, input int rs2,
                              input logic u1, input logic u2, input logic br,
                              input logic rv, input logic tk, input logic mb,
                              input logic [3:0] e);
    vec_t v;
    v.wb = wb; v.rd = AW'(rd); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
    v.u1 = u1; v.u2 = u2; v.br = br; v.rv = rv; v.tk = tk; v.mb = mb; v.exp = e;
    return v;
  endfunction

  // Counters read zero unless the perf-counter build is selected.
  function automatic logic [31:0] expc(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    rs1_used_ID = 0; rs2_used_ID = 0; WB_sel = 0; branch_ID = 0;
    br_resolve_valid = 0; branch_taken = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  // Load in EX writing r5, ID reads r5 through rs2.
  task automatic load_use_r5();
    WB_sel = 1; rd_EX = 5; rs2_ID = 5; rs2_used_ID = 1;
  endtask

  // Reference model: cycles still owed to each hazard.
  int          ld_left, fl_left;
  bit          bwait;
  logic [31:0] m_sc, m_fc;

  initial begin
    logic [3:0] e;
    bit hz;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tbl[1]  = mk(1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 4'b1100);
    tbl[2]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0000);  // x0 never hazards
    tbl[3]  = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0000);  // match but operand unused
    tbl[4]  = mk(0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 4'b0000);  // not a load
    tbl[5]  = mk(1, 7, 7, 3, 1, 1, 0, 0, 0, 0, 4'b1100);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100);  // branch in ID
    tbl[7]  = mk(1, 9, 9, 0, 1, 0, 1, 0, 0, 0, 4'b1100);  // load-use + branch
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0001);  // taken resolve
    tbl[9]  = mk(1, 5, 0, 5, 0, 1, 1, 1, 1, 0, 4'b0001);  // flush beats load-use
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1110);  // mem busy
    tbl[11] = mk(1, 5, 0, 5, 0, 1, 1, 1, 1, 1, 4'b1110);  // mem busy beats all
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000);  // not-taken in RUN

    // Reset state: outputs low even with hazard inputs present.
    idle();
    reset_n = 0;
    load_use_r5(); mem_busy = 1; branch_ID = 1;
    #2;
    chk("reset_outs", {28'd0, outs}, 32'd0);
    chk("reset_scnt", stall_cnt, 32'd0);
    chk("reset_fcnt", flush_cnt, 32'd0);
    do_reset();

    // Single-cycle decisions from RUN; async reset pulse returns to RUN.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      WB_sel = tbl[i].wb; rd_EX = tbl[i].rd; rs1_ID = tbl[i].rs1; rs2_ID = tbl[i].rs2;
      rs1_used_ID = tbl[i].u1; rs2_used_ID = tbl[i].u2; branch_ID = tbl[i].br;
      br_resolve_valid = tbl[i].rv; branch_taken = tbl[i].tk; mem_busy = tbl[i].mb;
      #1;
      chk($sformatf("vec%0d", i), {28'd0, outs}, {28'd0, tbl[i].exp});
      reset_n = 0;
      idle();
      #1 reset_n = 1;
    end

    // Load-use stall of 3 cycles, then branch wait 2 + flush 2.
    do_reset();
    load_use_r5();
    #1 chk("ld_c0", {28'd0, outs}, 32'b1100);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); idle();
      #1 chk($sformatf("ld_c%0d", c), {28'd0, outs}, 32'b1100);
    end
    @(negedge clk);
    #1 chk("ld_done", {28'd0, outs}, 32'b0000);
    branch_ID = 1;
    #1 chk("br_c0", {28'd0, outs}, 32'b1100);
    @(negedge clk); idle();
    #1 chk("br_c1", {28'd0, outs}, 32'b1100);
    @(negedge clk); br_resolve_valid = 1; branch_taken = 1;
    #1 chk("fl_c0", {28'd0, outs}, 32'b0001);
    @(negedge clk); idle();
    #1 chk("fl_c1", {28'd0, outs}, 32'b0001);
    @(negedge clk);
    #1 chk("fl_done", {28'd0, outs}, 32'b0000);
    chk("seq_scnt", stall_cnt, expc(32'd5));
    chk("seq_fcnt", flush_cnt, expc(32'd2));

    // mem_busy for 4 cycles mid load stall; remaining count resumes.
    do_reset();
    load_use_r5();
    @(negedge clk); idle();
    #1 chk("mb_ld1", {28'd0, outs}, 32'b1100);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); mem_busy = 1;
      #1 chk($sformatf("mb_busy%0d", c), {28'd0, outs}, 32'b1110);
    end
    @(negedge clk); mem_busy = 0;
    #1 chk("mb_resume", {28'd0, outs}, 32'b1100);
    @(negedge clk);
    #1 chk("mb_done", {28'd0, outs}, 32'b0000);
    chk("mb_scnt", stall_cnt, expc(32'd7));

    // Async reset in the middle of FLUSH.
    do_reset();
    br_resolve_valid = 1; branch_taken = 1;
    @(negedge clk); idle();
    #1 chk("rf_flush", {28'd0, outs}, 32'b0001);
    reset_n = 0;
    #1 chk("rf_async", {28'd0, outs}, 32'b0000);
    chk("rf_cnt", flush_cnt, 32'd0);
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    #1 chk("rf_after", {28'd0, outs}, 32'b0000);

    // Random traffic against the model.
    do_reset();
    ld_left = 0; fl_left = 0; bwait = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset_n          = ($urandom_range(99) != 0);
      WB_sel           = $urandom_range(1);
      rd_EX            = AW'($urandom_range(3));
      rs1_ID           = AW'($urandom_range(3));
      rs2_ID           = AW'($urandom_range(3));
      rs1_used_ID      = $urandom_range(1);
      rs2_used_ID      = $urandom_range(1);
      branch_ID        = ($urandom_range(4) == 0);
      br_resolve_valid = ($urandom_range(4) == 0);
      branch_taken     = $urandom_range(1);
      mem_busy         = ($urandom_range(6) == 0);
      #1;
      hz = WB_sel && rd_EX != 0 &&
           ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
      e = 4'b0000;
      if (!reset_n) begin
        ld_left = 0; fl_left = 0; bwait = 0; m_sc = 0; m_fc = 0;
      end else if (mem_busy) begin
        e = 4'b1110;
      end else if (br_resolve_valid && branch_taken) begin
        e = 4'b0001; fl_left = FLC - 1; ld_left = 0; bwait = 0;
      end else if (fl_left > 0) begin
        e = 4'b0001; fl_left--;
      end else if (ld_left > 0) begin
        e = 4'b1100; ld_left--;
      end else if (bwait) begin
        if (br_resolve_valid) bwait = 0;
        else                  e = 4'b1100;
      end else if (hz) begin
        e = 4'b1100; ld_left = LSC - 1;
      end else if (branch_ID) begin
        e = 4'b1100; bwait = 1;
      end
      chk($sformatf("rnd%0d_outs", n), {28'd0, outs}, {28'd0, e});
      chk($sformatf("rnd%0d_scnt", n), stall_cnt, expc(m_sc));
      chk($sformatf("rnd%0d_fcnt", n), flush_cnt, expc(m_fc));
      if (e[3] && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (e[0] && m_fc != 32'hFFFF_FFFF) m_fc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_STALL_CYC, default 1, load-use stall length in cycles (1..15).
REQ-003 SHALL have parameter FLUSH_CYC, default 1, flush length in cycles after a taken branch (1..15).
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_ID, rs2_ID  in  REG_ADDR_W  source indices in ID.
- rs1_used_ID, rs2_used_ID  in  1  source operand actually read.
- rd_EX  in  REG_ADDR_W  destination index in EX.
- WB_sel  in  1  EX instruction is a load.
- branch_ID  in  1  branch/jump decoded in ID.
- br_resolve_valid  in  1  branch outcome valid this cycle.
- branch_taken  in  1  outcome, qualified by br_resolve_valid.
- mem_busy  in  1  data memory not ready.
- stall_IFID, stall_IDEX, stall_EXMEM  out  1  hold the named pipeline register.
- flush  out  1  squash IF/ID and ID/EX.
- stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-005 SHALL implement FSM states RUN, LD_STALL, BR_WAIT, FLUSH, with a 4-bit down-counter cnt.
REQ-006 SHALL raise load-use hazard when WB_sel=1, rd_EX!=0, and (rs1_used_ID & rs1_ID==rd_EX) or (rs2_used_ID & rs2_ID==rd_EX); x0 SHALL never hazard.
REQ-007 SHALL, in RUN on load-use, assert stall_IFID and stall_IDEX combinationally that cycle; if LOAD_STALL_CYC>1, go to LD_STALL with cnt=LOAD_STALL_CYC-1.
REQ-008 SHALL, in LD_STALL, assert stall_IFID and stall_IDEX and decrement cnt; return to RUN on the edge where cnt==1, giving exactly LOAD_STALL_CYC total stall cycles.
REQ-009 SHALL, in RUN with branch_ID=1 and no load-use, assert stall_IFID and stall_IDEX that cycle and go to BR_WAIT; load-use SHALL take priority over branch_ID.
REQ-010 SHALL, in BR_WAIT, assert stall_IFID and stall_IDEX until br_resolve_valid=1; on that cycle stalls drop.
REQ-011 SHALL, on br_resolve_valid=1 with branch_taken=1 (any state), assert flush that cycle; if FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-1; else go to RUN.
REQ-012 SHALL, in FLUSH, assert flush, suppress all stall outputs, and decrement cnt; return to RUN on the edge where cnt==1.
REQ-013 SHALL return to RUN from BR_WAIT on br_resolve_valid=1 with branch_taken=0.
REQ-014 SHALL, while mem_busy=1, assert all three stalls, deassert flush, and freeze state and cnt; REQ-011 SHALL be deferred until mem_busy=0.
REQ-015 SHALL apply priority mem_busy > resolved-taken flush > load-use > branch_ID.
REQ-016 SHALL keep flush and stall_IFID mutually exclusive in every cycle.

Reset
REQ-017 SHALL, on reset_n=0, immediately force state=RUN, cnt=0, all stall outputs and flush to 0, and counters to 0, including mid-LD_STALL/BR_WAIT/FLUSH.
REQ-018 SHALL leave reset on the first clk rising edge after reset_n=1, with no residual stall or flush.

Configuration
REQ-019 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cnt each cycle stall_IFID=1 and flush_cnt each cycle flush=1, saturating at 0xFFFFFFFF.
REQ-020 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0 and omit counter registers; ports SHALL remain present.

Verification
REQ-021 SHALL cover LOAD_STALL_CYC=3, WB_sel=1, rd_EX=5, rs2_ID=5, rs2_used_ID=1 -> stall_IFID/IDEX high exactly 3 cycles, then RUN.
REQ-022 SHALL cover WB_sel=1, rd_EX=0, rs1_ID=0 -> no stall.
REQ-023 SHALL cover branch_ID=1, br_resolve_valid two cycles later with taken=1, FLUSH_CYC=2 -> stalls for 2 cycles, flush for 2 cycles, no overlap.
REQ-024 SHALL cover mem_busy=1 for 4 cycles during LD_STALL -> all stalls high, cnt frozen, load stall resumes with remaining count.
REQ-025 SHALL cover reset_n=0 asynchronously mid-FLUSH -> flush=0 immediately without a clock edge; state RUN.
REQ-026 SHALL cover, with HAZARD_PERF_CNT_EN, the REQ-021 plus REQ-023 sequence -> stall_cnt=5, flush_cnt=2.
